// File: rtl/vga_sync_monitor_pkg.sv
// Shared 640x480@60 timing defaults, FSM state encoding and counter helpers
// for the VGA sync monitor.
package vga_sync_monitor_pkg;

  localparam int H_TOTAL_DEF     = 800;
  localparam int H_SYNC_DEF      = 96;
  localparam int H_ACT_START_DEF = 144;
  localparam int H_ACT_END_DEF   = 784;
  localparam int V_TOTAL_DEF     = 521;
  localparam int V_SYNC_DEF      = 2;
  localparam int V_ACT_START_DEF = 31;
  localparam int V_ACT_END_DEF   = 511;
  localparam int LOCK_FRAMES_DEF = 2;

  localparam logic [9:0] CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Counters stick at full scale so an overrun still reads as a bad length.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_edge_sampler.sv
// Tick-qualified previous-sample registers and sync edge strobes.
// Define VGA_SYNC_MONITOR_SYNC_EN to add a 2-flop synchronizer on all inputs.
module vga_edge_sampler (
  input  logic clk,
  input  logic rst_n,
  input  logic pix_en,
  input  logic hsync_in,
  input  logic vsync_in,
  output logic tick,
  output logic h_fall,
  output logic h_rise,
  output logic v_fall,
  output logic v_rise
);

  logic pix_s;
  logic hs_s;
  logic vs_s;
  logic hs_prev;
  logic vs_prev;

`ifdef VGA_SYNC_MONITOR_SYNC_EN
  logic [1:0] pix_sync;
  logic [1:0] hs_sync;
  logic [1:0] vs_sync;

  // Syncs idle high, so the synchronizer resets to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_sync <= 2'b00;
      hs_sync  <= 2'b11;
      vs_sync  <= 2'b11;
    end else begin
      pix_sync <= {pix_sync[0], pix_en};
      hs_sync  <= {hs_sync[0], hsync_in};
      vs_sync  <= {vs_sync[0], vsync_in};
    end
  end

  assign pix_s = pix_sync[1];
  assign hs_s  = hs_sync[1];
  assign vs_s  = vs_sync[1];
`else
  assign pix_s = pix_en;
  assign hs_s  = hsync_in;
  assign vs_s  = vsync_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_prev <= 1'b1;
      vs_prev <= 1'b1;
    end else if (pix_s) begin
      hs_prev <= hs_s;
      vs_prev <= vs_s;
    end
  end

  assign tick   = pix_s;
  assign h_fall = pix_s &  hs_prev & ~hs_s;
  assign h_rise = pix_s & ~hs_prev &  hs_s;
  assign v_fall = pix_s &  vs_prev & ~vs_s;
  assign v_rise = pix_s & ~vs_prev &  vs_s;

endmodule

// File: rtl/vga_sync_monitor.sv
// Measures incoming VGA sync timing, locks after LOCK_FRAMES clean frames and
// reports active-pixel coordinates. Optional input sync: VGA_SYNC_MONITOR_SYNC_EN.
module vga_sync_monitor
  import vga_sync_monitor_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_ACT_START = H_ACT_START_DEF,
  parameter int H_ACT_END   = H_ACT_END_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_ACT_START = V_ACT_START_DEF,
  parameter int V_ACT_END   = V_ACT_END_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic       locked,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       in_active,
  output logic       frame_start,
  output logic       err,
  output logic [7:0] err_count,
  output state_t     state_dbg
);

  localparam logic [10:0] H_TOTAL_L   = 11'(H_TOTAL);
  localparam logic [9:0]  H_SYNC_L    = 10'(H_SYNC);
  localparam logic [9:0]  H_ACT_S_L   = 10'(H_ACT_START);
  localparam logic [9:0]  H_ACT_E_L   = 10'(H_ACT_END);
  localparam logic [10:0] V_TOTAL_L   = 11'(V_TOTAL);
  localparam logic [9:0]  V_SYNC_L    = 10'(V_SYNC);
  localparam logic [9:0]  V_ACT_S_L   = 10'(V_ACT_START);
  localparam logic [9:0]  V_ACT_E_L   = 10'(V_ACT_END);
  localparam logic [7:0]  LOCK_L      = 8'(LOCK_FRAMES);

  logic tick, h_fall, h_rise, v_fall, v_rise;

  vga_edge_sampler u_sampler (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_en   (pix_en),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .tick     (tick),
    .h_fall   (h_fall),
    .h_rise   (h_rise),
    .v_fall   (v_fall),
    .v_rise   (v_rise)
  );

  state_t     state, state_nxt;
  logic [9:0] h_cnt, h_cnt_nxt;
  logic [9:0] v_cnt, v_cnt_nxt;
  logic [7:0] good_cnt, good_nxt;
  logic       frame_bad, bad_nxt;
  logic       viol, err_nxt;
  logic       act_nxt;
  logic [9:0] x_nxt, y_nxt;

  // Widths are checked against the counter value that this tick produces,
  // so a rise on the first high tick reports exactly the number of low ticks.
  always_comb begin
    h_cnt_nxt = h_cnt;
    v_cnt_nxt = v_cnt;
    viol      = 1'b0;
    if (tick) begin
      h_cnt_nxt = h_fall ? 10'd0 : sat_inc(h_cnt);
      if (v_fall)      v_cnt_nxt = 10'd0;
      else if (h_fall) v_cnt_nxt = sat_inc(v_cnt);
      viol = (h_fall && (({1'b0, h_cnt} + 11'd1) != H_TOTAL_L)) ||
             (h_rise && (h_cnt_nxt != H_SYNC_L)) ||
             (v_fall && (({1'b0, v_cnt} + 11'd1) != V_TOTAL_L)) ||
             (v_rise && (v_cnt_nxt != V_SYNC_L));
    end
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    bad_nxt   = frame_bad;
    err_nxt   = 1'b0;
    unique case (state)
      SEARCH: begin
        if (v_fall) begin
          state_nxt = MEASURE;
          good_nxt  = 8'd0;
          bad_nxt   = 1'b0;
        end
      end
      MEASURE, LOCKED: begin
        if (viol) begin
          err_nxt   = 1'b1;
          state_nxt = MEASURE;
          good_nxt  = 8'd0;
          // A violation on the frame boundary still leaves the new frame clean.
          bad_nxt   = ~v_fall;
        end else if (v_fall) begin
          bad_nxt = 1'b0;
          if (state == MEASURE && !frame_bad) begin
            good_nxt = good_cnt + 8'd1;
            if (good_cnt + 8'd1 >= LOCK_L) state_nxt = LOCKED;
          end
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    act_nxt = (h_cnt_nxt >= H_ACT_S_L) && (h_cnt_nxt < H_ACT_E_L) &&
              (v_cnt_nxt >= V_ACT_S_L) && (v_cnt_nxt < V_ACT_E_L);
    x_nxt   = act_nxt ? h_cnt_nxt - H_ACT_S_L : 10'd0;
    y_nxt   = act_nxt ? v_cnt_nxt - V_ACT_S_L : 10'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEARCH;
      h_cnt       <= 10'd0;
      v_cnt       <= 10'd0;
      good_cnt    <= 8'd0;
      frame_bad   <= 1'b0;
      locked      <= 1'b0;
      x           <= 10'd0;
      y           <= 10'd0;
      in_active   <= 1'b0;
      frame_start <= 1'b0;
      err         <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      state       <= state_nxt;
      h_cnt       <= h_cnt_nxt;
      v_cnt       <= v_cnt_nxt;
      good_cnt    <= good_nxt;
      frame_bad   <= bad_nxt;
      locked      <= (state_nxt == LOCKED);
      frame_start <= v_fall;
      err         <= err_nxt;
      if (err_nxt && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (tick) begin
        in_active <= act_nxt;
        x         <= x_nxt;
        y         <= y_nxt;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a reduced 24x10 raster so that
// several full frames fit in a short run; expected values are hand-derived.
module tb_vga_sync_monitor;
  import vga_sync_monitor_pkg::*;

  localparam int HT  = 24;
  localparam int HS  = 4;
  localparam int HAS = 6;
  localparam int HAE = 22;
  localparam int VT  = 10;
  localparam int VS  = 2;
  localparam int VAS = 2;
  localparam int VAE = 8;
  localparam int LF  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_en;
  logic       hsync_in;
  logic       vsync_in;
  logic       locked;
  logic [9:0] x;
  logic [9:0] y;
  logic       in_active;
  logic       frame_start;
  logic       err;
  logic [7:0] err_count;
  state_t     state_dbg;

  int checks   = 0;
  int failures = 0;

  vga_sync_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT_END(HAE),
    .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACT_END(VAE),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .locked      (locked),
    .x           (x),
    .y           (y),
    .in_active   (in_active),
    .frame_start (frame_start),
    .err         (err),
    .err_count   (err_count),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  // One pixel tick every 4 clocks; returns on the negedge after the tick edge.
  task automatic drive_tick(input logic hs, input logic vs);
    repeat (3) @(negedge clk);
    hsync_in = hs;
    vsync_in = vs;
    pix_en   = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic send_line(input int sp, input int len, input bit vlow);
    for (int p = sp; p < len; p++)
      drive_tick((p < HS) ? 1'b0 : 1'b1, vlow ? 1'b0 : 1'b1);
  endtask

  task automatic send_frame();
    for (int l = 0; l < VT; l++) send_line(0, HT, l < VS);
  endtask

  // Remainder of a frame whose first tick was already driven.
  task automatic send_frame_tail();
    send_line(1, HT, 1'b1);
    for (int l = 1; l < VT; l++) send_line(0, HT, l < VS);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; pix_en = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({locked, in_active, frame_start, err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0000", {locked, in_active, frame_start, err});
    end
    checks++;
    if ({x, y, err_count} !== 28'd0) begin
      failures++;
      $display("FAIL reset_xy_cnt: x=%0d y=%0d err_count=%0d expected 0", x, y, err_count);
    end
    checks++;
    if (state_dbg !== SEARCH) begin
      failures++;
      $display("FAIL reset_state: got %0d expected %0d", state_dbg, SEARCH);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_no_tick();
    hsync_in = 1'b0; vsync_in = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (frame_start !== 1'b0 || state_dbg !== SEARCH) begin
      failures++;
      $display("FAIL no_tick_ignored: frame_start=%0b state=%0d expected 0/%0d", frame_start, state_dbg, SEARCH);
    end
    hsync_in = 1'b1; vsync_in = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lock();
    send_frame();
    send_frame();
    checks++;
    if (locked !== 1'b0 || state_dbg !== MEASURE) begin
      failures++;
      $display("FAIL prelock: locked=%0b state=%0d expected 0/%0d", locked, state_dbg, MEASURE);
    end
    drive_tick(1'b0, 1'b0);
    checks++;
    if (locked !== 1'b1 || frame_start !== 1'b1) begin
      failures++;
      $display("FAIL lock_3rd_fall: locked=%0b frame_start=%0b expected 1/1", locked, frame_start);
    end
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b0) begin
      failures++;
      $display("FAIL frame_start_width: got %0b expected 0", frame_start);
    end
    send_frame_tail();
    checks++;
    if (err_count !== 8'd0 || locked !== 1'b1) begin
      failures++;
      $display("FAIL lock_clean: err_count=%0d locked=%0b expected 0/1", err_count, locked);
    end
  endtask

  task automatic test_active();
    for (int l = 0; l < VT; l++) begin
      for (int p = 0; p < HT; p++) begin
        drive_tick((p < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1);
        if (l == 2 && p == 5) begin
          checks++;
          if (in_active !== 1'b0 || x !== 10'd0) begin
            failures++;
            $display("FAIL act_before_h: in_active=%0b x=%0d expected 0/0", in_active, x);
          end
        end
        if (l == 2 && p == 6) begin
          checks++;
          if (in_active !== 1'b1 || x !== 10'd0 || y !== 10'd0) begin
            failures++;
            $display("FAIL act_first: in_active=%0b x=%0d y=%0d expected 1/0/0", in_active, x, y);
          end
        end
        if (l == 7 && p == 21) begin
          checks++;
          if (in_active !== 1'b1 || x !== 10'd15 || y !== 10'd5) begin
            failures++;
            $display("FAIL act_last: in_active=%0b x=%0d y=%0d expected 1/15/5", in_active, x, y);
          end
        end
        if (l == 7 && p == 22) begin
          checks++;
          if (in_active !== 1'b0 || x !== 10'd0 || y !== 10'd0) begin
            failures++;
            $display("FAIL act_h_end: in_active=%0b x=%0d y=%0d expected 0/0/0", in_active, x, y);
          end
        end
        if (l == 8 && p == 6) begin
          checks++;
          if (in_active !== 1'b0) begin
            failures++;
            $display("FAIL act_v_end: in_active=%0b expected 0", in_active);
          end
        end
      end
    end
  endtask

  task automatic test_line_error();
    for (int l = 0; l < VT; l++) begin
      for (int p = 0; p < ((l == 4) ? HT - 1 : HT); p++) begin
        drive_tick((p < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1);
        if (l == 5 && p == 0) begin
          checks++;
          if (err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1) begin
            failures++;
            $display("FAIL short_line: err=%0b locked=%0b err_count=%0d expected 1/0/1", err, locked, err_count);
          end
        end
        if (l == 5 && p == 1) begin
          checks++;
          if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_width: err=%0b expected 0", err);
          end
        end
      end
    end
    send_frame();
    send_frame();
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL relock_early: locked=%0b expected 0", locked);
    end
    drive_tick(1'b0, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL relock: locked=%0b expected 1", locked);
    end
    send_frame_tail();
  endtask

  task automatic test_vsync_width();
    for (int l = 0; l < VT; l++) begin
      for (int p = 0; p < HT; p++) begin
        drive_tick((p < HS) ? 1'b0 : 1'b1, (l < 3) ? 1'b0 : 1'b1);
        if (l == 3 && p == 0) begin
          checks++;
          if (err !== 1'b1 || err_count !== 8'd2) begin
            failures++;
            $display("FAIL vsync_wide: err=%0b err_count=%0d expected 1/2", err, err_count);
          end
        end
      end
    end
    for (int l = 0; l < VT; l++) begin
      for (int p = 0; p < HT; p++) begin
        drive_tick((p < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1);
        if (l == 0 && p == 0) begin
          checks++;
          if (frame_start !== 1'b1) begin
            failures++;
            $display("FAIL coincident_fall: frame_start=%0b expected 1", frame_start);
          end
        end
        if (l == 3 && p == 6) begin
          checks++;
          if (in_active !== 1'b1 || x !== 10'd0 || y !== 10'd1) begin
            failures++;
            $display("FAIL vcnt_zero: in_active=%0b x=%0d y=%0d expected 1/0/1", in_active, x, y);
          end
        end
      end
    end
    send_frame();
    drive_tick(1'b0, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL relock_vs: locked=%0b expected 1", locked);
    end
    send_frame_tail();
  endtask

  task automatic test_reset_mid();
    for (int l = 0; l < 4; l++) send_line(0, HT, l < VS);
    send_line(0, 11, 1'b0);
    checks++;
    if (in_active !== 1'b1 || x !== 10'd4 || y !== 10'd2) begin
      failures++;
      $display("FAIL pre_reset_act: in_active=%0b x=%0d y=%0d expected 1/4/2", in_active, x, y);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({locked, in_active, err, frame_start} !== 4'b0000 || {x, y, err_count} !== 28'd0) begin
      failures++;
      $display("FAIL async_reset: flags=%b x=%0d y=%0d err_count=%0d expected all 0",
               {locked, in_active, err, frame_start}, x, y, err_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_line(11, HT, 1'b0);
    for (int l = 5; l < VT; l++) send_line(0, HT, 1'b0);
    checks++;
    if (state_dbg !== SEARCH || locked !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_search: state=%0d locked=%0b expected %0d/0", state_dbg, locked, SEARCH);
    end
    send_frame();
    send_frame();
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL reset_lock_early: locked=%0b expected 0", locked);
    end
    drive_tick(1'b0, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL reset_relock: locked=%0b expected 1", locked);
    end
    send_frame_tail();
  endtask

  task automatic test_err_saturation();
    for (int i = 0; i < 100; i++) send_line(0, 5, 1'b0);
    checks++;
    if (err_count !== 8'd99 || locked !== 1'b0) begin
      failures++;
      $display("FAIL err_count_99: err_count=%0d locked=%0b expected 99/0", err_count, locked);
    end
    for (int i = 0; i < 200; i++) send_line(0, 5, 1'b0);
    checks++;
    if (err_count !== 8'd255) begin
      failures++;
      $display("FAIL err_count_sat: err_count=%0d expected 255", err_count);
    end
    for (int i = 0; i < 10; i++) send_line(0, 5, 1'b0);
    drive_tick(1'b0, 1'b1);
    checks++;
    if (err !== 1'b1 || err_count !== 8'd255) begin
      failures++;
      $display("FAIL err_count_hold: err=%0b err_count=%0d expected 1/255", err, err_count);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_no_tick();
    test_lock();
    test_active();
    test_line_error();
    test_vsync_width();
    test_reset_mid();
    test_err_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
